astra_pifo_child_bank: RTL and testbench
========================================

Name: astra_pifo_child_bank

Overview:
- Child-side responder for the Astra PIFO node.
- Holds four independent sorted lanes, one per child slot of the parent node.
- Accepts the parent's downward push and pop requests.
- Continuously presents each lane's head entry upward on the 4-wide child data bus the parent compares.
- An empty lane presents all-ones, which the parent treats as lowest urgency.

Parameters:
- PTW, 16, priority field width; smaller value = more urgent.
- MTW, 32, metadata field width.
- DEPTH, 8, entries per lane (≥2).
- CW, $clog2(DEPTH+1), per-lane occupancy counter width (derived, do not override).

Ports:
- i_clk  in  1  clock.
- i_arst_n  in  1  asynchronous active-low reset.
- i_push  in  4  per-lane push strobe; expected one-hot or zero.
- i_push_data  in  MTW+PTW  entry {meta, prio}, prio in [PTW-1:0]; shared by all lanes.
- i_pop  in  4  per-lane pop strobe; any combination legal.
- o_pop_data  out  4*(MTW+PTW)  lane k head at [k*(MTW+PTW) +: MTW+PTW]; all-ones when lane empty.
- o_empty  out  4  lane empty flags.
- o_full  out  4  lane full flags.
- o_cnt  out  4*CW  per-lane occupancy.
- o_ovf  out  1  one-cycle pulse: push dropped on full lane.
- o_udf  out  1  one-cycle pulse: pop on empty lane ignored.

Behaviour:
- Reset (async assert, sync release):
  - All entries = all-ones; o_cnt = 0; o_empty = 4'hF; o_full = 0; o_ovf = o_udf = 0.
  - o_pop_data = all-ones.
  - Reset mid-operation discards all contents immediately.
- Lane storage:
  - Register array kept sorted ascending by prio; slot 0 is the head.
  - Unused slots hold all-ones.
- Insert rule:
  - New entry goes after all entries with prio ≤ new prio, so equal priorities are FIFO.
  - Compare is unsigned on the PTW prio bits only.
- Latency:
  - All updates occur at the rising edge.
  - o_pop_data, flags and counters are direct register outputs, reflecting the new state one cycle after the strobe.
  - No combinational path from inputs to outputs.
- Push, lane k, no pop:
  - Not full: insert, cnt+1.
  - Full: entry dropped, contents unchanged, o_ovf=1 next cycle.
- Pop, lane k, no push:
  - Not empty: remove head, shift remaining entries toward slot 0, fill the vacated tail with all-ones, cnt−1.
  - Empty: no change, o_udf=1.
  - Popped data is the o_pop_data value visible during the pop cycle; the parent samples it there.
- Simultaneous push+pop on the same lane:
  - Not empty: result = old contents minus head, plus new entry inserted sorted; cnt unchanged.
  - This is legal even when full; no o_ovf.
  - If new prio < all remaining entries, it becomes the next head.
  - Empty: pop ignored with o_udf=1; push proceeds, cnt=1.
- Multi-bit i_push:
  - Only the lowest-index set lane accepts; the others are ignored silently.
- Lanes are fully independent: pops on several lanes plus a push on one lane all happen in the same cycle.
- o_full[k] = (cnt==DEPTH); o_empty[k] = (cnt==0).
- o_ovf/o_udf are ORed across lanes and registered.

Test Plan:
- Reset then idle:
  - o_pop_data = all-ones (4×48 bits), o_empty=4'hF, o_cnt=0.
  - Assert arst_n low mid-run after pushes: same values immediately.
- Push lane0 prio 50/AAAA, 20/BBBB, 80/CCCC, 10/DDDD (one per cycle):
  - Lane0 head = 10/DDDD, cnt=4.
  - Pops then yield 10, 20, 50, 80, then lane0 = all-ones, o_empty[0]=1.
- Equal priorities: push lane1 30/0001 then 30/0002 -> pops return 0001 then 0002.
- Head 20/BBBB with cnt=3, push+pop lane0 with 5/EEEE:
  - Next cycle head = 5/EEEE, cnt=3.
  - Next pop returns 5, then 50.
- Fill lane2 with DEPTH entries:
  - Further push -> o_ovf pulse 1 cycle, cnt stays DEPTH.
  - Push+pop while full -> no o_ovf, cnt=DEPTH.
- Pop empty lane3 -> o_udf pulse, no change.
- i_push=4'b0110 with 7/1234 -> only lane1 gains the entry.
- i_pop=4'hF with lanes 0-2 non-empty: all three heads advance in the same cycle.

Source files
------------

// File: rtl/astra_pifo_child_bank.sv
// Astra PIFO child bank: four independent sorted lanes that serve the
// parent's push/pop requests and present each lane's head upward.
//
// Ports:
//   i_clk, i_arst_n  clock, async active-low reset
//   i_push [3:0]     per-lane push strobe (lowest set lane wins)
//   i_push_data      shared entry {meta, prio}
//   i_pop  [3:0]     per-lane pop strobe
//   o_pop_data       lane k head at [k*W +: W], all-ones when empty
//   o_empty/o_full   per-lane flags
//   o_cnt            per-lane occupancy, CW bits each
//   o_ovf/o_udf      registered drop/underflow pulses
module astra_pifo_child_bank #(
  parameter int PTW   = 16,
  parameter int MTW   = 32,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic [3:0]                 i_push,
  input  logic [MTW+PTW-1:0]         i_push_data,
  input  logic [3:0]                 i_pop,
  output logic [4*(MTW+PTW)-1:0]     o_pop_data,
  output logic [3:0]                 o_empty,
  output logic [3:0]                 o_full,
  output logic [4*CW-1:0]            o_cnt,
  output logic                       o_ovf,
  output logic                       o_udf
);

  localparam int W = MTW + PTW;
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [W-1:0]     ent_q [4][DEPTH];
  logic [W-1:0]     ent_d [4][DEPTH];
  logic [W-1:0]     base  [4][DEPTH];
  logic [DEPTH-1:0] ge    [4];
  logic [CW-1:0]    cnt_q [4];
  logic [CW-1:0]    cnt_d [4];
  logic [CW-1:0]    bcnt  [4];
  logic [3:0]       empty_q, empty_d;
  logic [3:0]       full_q, full_d;
  logic [3:0]       pop_ok, push_ok;
  logic [3:0]       psel;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  // isolate lowest set push bit
  assign psel = i_push & (~i_push + 4'd1);

  always_comb begin
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    pop_ok  = '0;
    push_ok = '0;
    empty_d = '0;
    full_d  = '0;
    for (int k = 0; k < 4; k++) begin
      pop_ok[k]  = i_pop[k] && !empty_q[k];
      // a pop in the same cycle frees a slot, so full is no obstacle
      push_ok[k] = psel[k] && (!full_q[k] || pop_ok[k]);
      ovf_d      = ovf_d | (psel[k] && full_q[k] && !pop_ok[k]);
      udf_d      = udf_d | (i_pop[k] && empty_q[k]);
      bcnt[k]    = cnt_q[k] - CW'(pop_ok[k]);

      for (int i = 0; i < DEPTH; i++)
        base[k][i] = ent_q[k][i];
      if (pop_ok[k]) begin
        for (int i = 0; i < DEPTH-1; i++)
          base[k][i] = ent_q[k][i+1];
        base[k][DEPTH-1] = '1;
      end

      // ge is a prefix mask: valid entries that stay ahead of the new one
      for (int i = 0; i < DEPTH; i++)
        ge[k][i] = (CW'(i) < bcnt[k]) &&
                   (base[k][i][PTW-1:0] <= i_push_data[PTW-1:0]);

      for (int i = 0; i < DEPTH; i++)
        ent_d[k][i] = base[k][i];
      if (push_ok[k]) begin
        if (!ge[k][0])
          ent_d[k][0] = i_push_data;
        for (int i = 1; i < DEPTH; i++)
          if (!ge[k][i])
            ent_d[k][i] = ge[k][i-1] ? i_push_data
                                     : base[k][i-1];
      end

      cnt_d[k]   = bcnt[k] + CW'(push_ok[k]);
      empty_d[k] = (cnt_d[k] == '0);
      full_d[k]  = (cnt_d[k] == FULLC);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < DEPTH; i++)
          ent_q[k][i] <= '1;
        cnt_q[k] <= '0;
      end
      empty_q <= 4'hF;
      full_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < DEPTH; i++)
          ent_q[k][i] <= ent_d[k][i];
        cnt_q[k] <= cnt_d[k];
      end
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_comb begin
    o_pop_data = '0;
    o_cnt      = '0;
    for (int k = 0; k < 4; k++) begin
      o_pop_data[k*W +: W] = ent_q[k][0];
      o_cnt[k*CW +: CW]    = cnt_q[k];
    end
  end

  assign o_empty = empty_q;
  assign o_full  = full_q;
  assign o_ovf   = ovf_q;
  assign o_udf   = udf_q;

endmodule

// File: tb/tb_astra_pifo_child_bank.sv
// Directed bench for astra_pifo_child_bank.
// Each scenario task drives vectors and checks hand-computed values.
module tb_astra_pifo_child_bank;

  localparam int PTW = 16;
  localparam int MTW = 32;
  localparam int DEPTH = 8;
  localparam int CW = 4;
  localparam int W = 48;
  localparam logic [W-1:0] ONES = '1;

  logic           clk;
  logic           rst_n;
  logic [3:0]     push;
  logic [W-1:0]   pdata;
  logic [3:0]     pop;
  logic [4*W-1:0] pop_data;
  logic [3:0]     empty;
  logic [3:0]     full;
  logic [4*CW-1:0] cnt;
  logic           ovf;
  logic           udf;

  int n_chk;
  int n_fail;

  astra_pifo_child_bank #(.PTW(PTW), .MTW(MTW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_push(push),
    .i_push_data(pdata), .i_pop(pop), .o_pop_data(pop_data),
    .o_empty(empty), .o_full(full), .o_cnt(cnt),
    .o_ovf(ovf), .o_udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ent(input logic [31:0] m,
                                      input logic [15:0] p);
    return {m, p};
  endfunction

  function automatic logic [W-1:0] head(input int k);
    return pop_data[k*W +: W];
  endfunction

  function automatic logic [CW-1:0] lc(input int k);
    return cnt[k*CW +: CW];
  endfunction

  task automatic cyc(input logic [3:0] pu, input logic [W-1:0] d,
                     input logic [3:0] po);
    push = pu; pdata = d; pop = po;
    @(posedge clk); #1;
    push = '0; pop = '0; pdata = '0;
  endtask

  task automatic test_reset();
    n_chk++;
    if (pop_data !== {4{ONES}}) begin
      n_fail++; $display("FAIL reset_data got %h exp all-ones", pop_data);
    end
    n_chk++;
    if (empty !== 4'hF || full !== 4'h0) begin
      n_fail++; $display("FAIL reset_flags got e=%h f=%h exp e=F f=0", empty, full);
    end
    n_chk++;
    if (cnt !== '0 || ovf !== 1'b0 || udf !== 1'b0) begin
      n_fail++; $display("FAIL reset_cnt got c=%h o=%b u=%b exp 0", cnt, ovf, udf);
    end
  endtask

  task automatic test_sort();
    logic [W-1:0] exp_q [4];
    exp_q[0] = ent(32'hDDDD, 16'd10);
    exp_q[1] = ent(32'hBBBB, 16'd20);
    exp_q[2] = ent(32'hAAAA, 16'd50);
    exp_q[3] = ent(32'hCCCC, 16'd80);
    cyc(4'b0001, ent(32'hAAAA, 16'd50), 4'b0);
    cyc(4'b0001, ent(32'hBBBB, 16'd20), 4'b0);
    cyc(4'b0001, ent(32'hCCCC, 16'd80), 4'b0);
    cyc(4'b0001, ent(32'hDDDD, 16'd10), 4'b0);
    n_chk++;
    if (lc(0) !== 4'd4) begin
      n_fail++; $display("FAIL sort_cnt got %0d exp 4", lc(0));
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (head(0) !== exp_q[i]) begin
        n_fail++; $display("FAIL sort_pop%0d got %h exp %h", i, head(0), exp_q[i]);
      end
      cyc(4'b0, '0, 4'b0001);
    end
    n_chk++;
    if (head(0) !== ONES || empty[0] !== 1'b1) begin
      n_fail++; $display("FAIL sort_empty got %h e=%b exp ones e=1", head(0), empty[0]);
    end
  endtask

  task automatic test_fifo_equal();
    cyc(4'b0010, ent(32'h0001, 16'd30), 4'b0);
    cyc(4'b0010, ent(32'h0002, 16'd30), 4'b0);
    n_chk++;
    if (head(1) !== ent(32'h0001, 16'd30)) begin
      n_fail++; $display("FAIL fifo_first got %h exp 0001/30", head(1));
    end
    cyc(4'b0, '0, 4'b0010);
    n_chk++;
    if (head(1) !== ent(32'h0002, 16'd30)) begin
      n_fail++; $display("FAIL fifo_second got %h exp 0002/30", head(1));
    end
    cyc(4'b0, '0, 4'b0010);
    n_chk++;
    if (empty[1] !== 1'b1) begin
      n_fail++; $display("FAIL fifo_empty got %b exp 1", empty[1]);
    end
  endtask

  task automatic test_push_pop();
    cyc(4'b0001, ent(32'hAAAA, 16'd50), 4'b0);
    cyc(4'b0001, ent(32'hBBBB, 16'd20), 4'b0);
    cyc(4'b0001, ent(32'hCCCC, 16'd80), 4'b0);
    n_chk++;
    if (head(0) !== ent(32'hBBBB, 16'd20) || lc(0) !== 4'd3) begin
      n_fail++; $display("FAIL pp_setup got %h c=%0d exp BBBB/20 c=3", head(0), lc(0));
    end
    cyc(4'b0001, ent(32'hEEEE, 16'd5), 4'b0001);
    n_chk++;
    if (head(0) !== ent(32'hEEEE, 16'd5) || lc(0) !== 4'd3) begin
      n_fail++; $display("FAIL pp_head got %h c=%0d exp EEEE/5 c=3", head(0), lc(0));
    end
    cyc(4'b0, '0, 4'b0001);
    n_chk++;
    if (head(0) !== ent(32'hAAAA, 16'd50) || lc(0) !== 4'd2) begin
      n_fail++; $display("FAIL pp_next got %h c=%0d exp AAAA/50 c=2", head(0), lc(0));
    end
    cyc(4'b0, '0, 4'b0001);
    cyc(4'b0, '0, 4'b0001);
  endtask

  task automatic test_full();
    for (int i = 1; i <= DEPTH; i++)
      cyc(4'b0100, ent(32'h100 + 32'(i), 16'(i*10)), 4'b0);
    n_chk++;
    if (full[2] !== 1'b1 || lc(2) !== 4'd8) begin
      n_fail++; $display("FAIL full_fill got f=%b c=%0d exp f=1 c=8", full[2], lc(2));
    end
    cyc(4'b0100, ent(32'h999, 16'd1), 4'b0);
    n_chk++;
    if (ovf !== 1'b1 || lc(2) !== 4'd8 || head(2) !== ent(32'h101, 16'd10)) begin
      n_fail++; $display("FAIL full_ovf got o=%b c=%0d h=%h exp o=1 c=8 h=101/10", ovf, lc(2), head(2));
    end
    cyc(4'b0, '0, 4'b0);
    n_chk++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL full_ovf_pulse got %b exp 0", ovf);
    end
    cyc(4'b0100, ent(32'h777, 16'd100), 4'b0100);
    n_chk++;
    if (ovf !== 1'b0 || lc(2) !== 4'd8 || head(2) !== ent(32'h102, 16'd20)) begin
      n_fail++; $display("FAIL full_pp got o=%b c=%0d h=%h exp o=0 c=8 h=102/20", ovf, lc(2), head(2));
    end
    for (int i = 0; i < DEPTH; i++)
      cyc(4'b0, '0, 4'b0100);
    n_chk++;
    if (empty[2] !== 1'b1 || head(2) !== ONES) begin
      n_fail++; $display("FAIL full_drain got e=%b h=%h exp e=1 ones", empty[2], head(2));
    end
  endtask

  task automatic test_udf();
    cyc(4'b0, '0, 4'b1000);
    n_chk++;
    if (udf !== 1'b1 || lc(3) !== 4'd0 || head(3) !== ONES) begin
      n_fail++; $display("FAIL udf_pulse got u=%b c=%0d h=%h exp u=1 c=0 ones", udf, lc(3), head(3));
    end
    cyc(4'b0, '0, 4'b0);
    n_chk++;
    if (udf !== 1'b0) begin
      n_fail++; $display("FAIL udf_clear got %b exp 0", udf);
    end
  endtask

  task automatic test_multi_push();
    cyc(4'b0110, ent(32'h1234, 16'd7), 4'b0);
    n_chk++;
    if (lc(1) !== 4'd1 || head(1) !== ent(32'h1234, 16'd7)) begin
      n_fail++; $display("FAIL multi_lane1 got c=%0d h=%h exp c=1 1234/7", lc(1), head(1));
    end
    n_chk++;
    if (lc(2) !== 4'd0 || empty[2] !== 1'b1) begin
      n_fail++; $display("FAIL multi_lane2 got c=%0d e=%b exp c=0 e=1", lc(2), empty[2]);
    end
    cyc(4'b0, '0, 4'b0010);
  endtask

  task automatic test_pop_all();
    cyc(4'b0001, ent(32'hA1, 16'd10), 4'b0);
    cyc(4'b0010, ent(32'hB1, 16'd20), 4'b0);
    cyc(4'b0001, ent(32'hA2, 16'd15), 4'b0);
    cyc(4'b0100, ent(32'hC1, 16'd30), 4'b0);
    cyc(4'b0010, ent(32'hB2, 16'd25), 4'b0);
    cyc(4'b0100, ent(32'hC2, 16'd35), 4'b0);
    cyc(4'b0, '0, 4'hF);
    n_chk++;
    if (head(0) !== ent(32'hA2, 16'd15) || head(1) !== ent(32'hB2, 16'd25) ||
        head(2) !== ent(32'hC2, 16'd35)) begin
      n_fail++; $display("FAIL popall_heads got %h %h %h exp A2/15 B2/25 C2/35", head(0), head(1), head(2));
    end
    n_chk++;
    if (cnt !== 16'h0111 || udf !== 1'b1) begin
      n_fail++; $display("FAIL popall_cnt got c=%h u=%b exp c=0111 u=1", cnt, udf);
    end
  endtask

  task automatic test_reset_mid();
    cyc(4'b1000, ent(32'h55, 16'd3), 4'b0);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (pop_data !== {4{ONES}} || empty !== 4'hF || cnt !== '0) begin
      n_fail++; $display("FAIL mid_reset got d=%h e=%h c=%h exp ones F 0", pop_data, empty, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (empty !== 4'hF || udf !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL post_reset got e=%h o=%b u=%b exp F 0 0", empty, ovf, udf);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    push = '0; pop = '0; pdata = '0;
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_sort();
    test_fifo_equal();
    test_push_pop();
    test_full();
    test_udf();
    test_multi_push();
    test_pop_all();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
